uart_bus_bridge: RTL and testbench

//  Bus initiator driven by a byte stream; the master-side counterpart of bus-slave peripherals (e.g. uart_controller).

---
 rtl/uart_bus_bridge_pkg.sv | 20 ++
 rtl/uart_bus_bridge_if.sv | 18 +
 rtl/uart_bus_bridge_shreg.sv | 28 ++
 rtl/uart_bus_bridge.sv | 157 +++++++++++++++
 tb/tb_uart_bus_bridge.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and byte constants for the UART-to-bus bridge.
//   state_t      : packet parser / transfer FSM states
//   CMD_* / RSP_*: protocol bytes seen on the byte stream
package uart_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Simple single-transfer SoC bus.
//   master drives : en, rnw, address, data_m2s
//   slave drives  : data_s2m, rdy
// A transfer completes in the cycle en && rdy.
interface bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_m2s;
  logic [DATA_WIDTH-1:0] data_s2m;
  logic                  rdy;

  modport master (output en, rnw, address, data_m2s, input data_s2m, rdy);
  modport slave  (input en, rnw, address, data_m2s, output data_s2m, rdy);
endinterface

// File: rtl/uart_bus_bridge_shreg.sv
// Width-parameterised byte shift register.
//   clk, rst    : clock, synchronous active-high reset (clears to 0)
//   i_load      : parallel load of i_load_val (priority over shift)
//   i_shift     : shift left one byte, i_byte enters at the LSB end
//   o_q         : register contents; MSB byte is the next byte out
module uart_bus_bridge_shreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)          r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_shift) r_q <= (r_q << 8) | W'(i_byte);
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// Byte-stream driven bus initiator (host debug/load path onto the SoC bus).
// Packet: cmd, NA address bytes MSB first, (write) ND data bytes MSB first.
// Responses: write 'K', read ND data bytes MSB first, unknown cmd '?',
// bus timeout 'T' (only when UART_BUS_BRIDGE_TIMEOUT_EN is defined).
//   clk, rst            : clock, synchronous active-high reset
//   i_rx_data/valid, o_rx_ready : command byte source handshake
//   o_tx_data/valid, i_tx_ready : response byte sink handshake
//   bus                 : bus_if master port
// Optional feature macro: UART_BUS_BRIDGE_TIMEOUT_EN (bus wait limit).
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  bus_if.master      bus
);

  localparam int NA      = ADDR_WIDTH / 8;
  localparam int ND      = DATA_WIDTH / 8;
  localparam int LEN_MAX = (NA > ND) ? NA : ND;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  localparam int CNT_MAX = (LEN_MAX > TIMEOUT_CYCLES) ? LEN_MAX : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX = LEN_MAX;
`endif
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rx_ready, r_tx_valid, r_en, r_rnw, r_resp_multi;
  logic                  w_rx_fire, w_tx_fire, w_cnt_inc;
  logic                  w_addr_shift, w_wdata_shift, w_resp_shift;
  logic                  w_resp_load, w_resp_multi;
  logic [DATA_WIDTH-1:0] w_resp_val, w_resp_q, w_wdata;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_rx_fire = i_rx_valid && r_rx_ready;
  assign w_tx_fire = r_tx_valid && i_tx_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_inc     = 1'b0;
    w_addr_shift  = 1'b0;
    w_wdata_shift = 1'b0;
    w_resp_shift  = 1'b0;
    w_resp_load   = 1'b0;
    w_resp_multi  = 1'b0;
    w_resp_val    = '0;
    case (r_state)
      ST_IDLE: if (w_rx_fire) begin
        if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_resp_load = 1'b1;
          w_resp_val  = DATA_WIDTH'(RSP_ERR) << (DATA_WIDTH - 8);
          w_state_nxt = ST_RESP;
        end
      end
      ST_ADDR: if (w_rx_fire) begin
        w_addr_shift = 1'b1;
        w_cnt_inc    = 1'b1;
        if (r_cnt == CNT_W'(NA - 1)) w_state_nxt = r_rnw ? ST_BUS : ST_DATA;
      end
      ST_DATA: if (w_rx_fire) begin
        w_wdata_shift = 1'b1;
        w_cnt_inc     = 1'b1;
        if (r_cnt == CNT_W'(ND - 1)) w_state_nxt = ST_BUS;
      end
      ST_BUS: begin
        // en is high exactly while in BUS, so rdy here means en && rdy
        if (bus.rdy) begin
          w_resp_load  = 1'b1;
          w_resp_multi = r_rnw;
          w_resp_val   = r_rnw ? bus.data_s2m : (DATA_WIDTH'(RSP_ACK) << (DATA_WIDTH - 8));
          w_state_nxt  = ST_RESP;
        end
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        else begin
          w_cnt_inc = 1'b1;
          if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_resp_load = 1'b1;
            w_resp_val  = DATA_WIDTH'(RSP_TMO) << (DATA_WIDTH - 8);
            w_state_nxt = ST_RESP;
          end
        end
`endif
      end
      ST_RESP: if (w_tx_fire) begin
        w_resp_shift = 1'b1;
        w_cnt_inc    = 1'b1;
        if (!r_resp_multi || r_cnt == CNT_W'(ND - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so rx_ready is
  // never high outside IDLE/ADDR/DATA and en/tx_valid follow their states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rx_ready   <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_en         <= 1'b0;
      r_rnw        <= 1'b1;
      r_resp_multi <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ADDR) ||
                    (w_state_nxt == ST_DATA);
      r_en       <= (w_state_nxt == ST_BUS);
      r_tx_valid <= (w_state_nxt == ST_RESP);
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_IDLE && w_rx_fire &&
          (i_rx_data == CMD_WR || i_rx_data == CMD_RD))
        r_rnw <= (i_rx_data == CMD_RD);
      if (w_resp_load) r_resp_multi <= w_resp_multi;
    end
  end

  uart_bus_bridge_shreg #(.W(ADDR_WIDTH)) u_addr (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_val('0),
    .i_shift(w_addr_shift), .i_byte(i_rx_data), .o_q(w_addr)
  );

  uart_bus_bridge_shreg #(.W(DATA_WIDTH)) u_wdata (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_load_val('0),
    .i_shift(w_wdata_shift), .i_byte(i_rx_data), .o_q(w_wdata)
  );

  // Response serialiser: MSB byte is always the byte on o_tx_data
  uart_bus_bridge_shreg #(.W(DATA_WIDTH)) u_resp (
    .clk(clk), .rst(rst), .i_load(w_resp_load), .i_load_val(w_resp_val),
    .i_shift(w_resp_shift), .i_byte(8'h00), .o_q(w_resp_q)
  );

  assign o_rx_ready   = r_rx_ready;
  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = w_resp_q[DATA_WIDTH-1 -: 8];
  assign bus.en       = r_en;
  assign bus.rnw      = r_rnw;
  assign bus.address  = w_addr;
  assign bus.data_m2s = w_wdata;

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;

  always #5 clk = ~clk;

  bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  uart_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .bus(bus)
  );

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_exp_t;

  bus_exp_t    busq[$];
  logic [7:0]  txq[$];
  int          checks = 0, errors = 0;
  int          slave_delay = 0, tx_stall = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          en_rise = 0, en_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic rnw, input logic [31:0] addr, input logic [31:0] data);
    bus_exp_t e;
    e.rnw = rnw; e.addr = addr; e.data = data;
    busq.push_back(e);
  endtask

  // Bus slave + bus monitor: rdy is raised slave_delay cycles into en;
  // the transfer then completes at the following posedge.
  initial begin
    int       wc = 0;
    logic     en_prev = 1'b0, done_prev = 1'b0, done;
    bus_exp_t e;
    bus.rdy = 1'b0;
    bus.data_s2m = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (done_prev) chk("no_b2b_en", 32'(bus.en), 32'h0);
      if (bus.en && !rst) begin
        en_cyc++;
        if (!en_prev) en_rise++;
        if (wc >= slave_delay) begin
          bus.rdy = 1'b1;
          bus.data_s2m = slave_rdata;
          done = 1'b1;
          if (busq.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected actual addr=%0h required none", bus.address);
          end else begin
            e = busq.pop_front();
            chk("bus_rnw", 32'(bus.rnw), 32'(e.rnw));
            chk("bus_addr", bus.address, e.addr);
            if (!e.rnw) chk("bus_wdata", bus.data_m2s, e.data);
          end
        end else begin
          bus.rdy = 1'b0;
          bus.data_s2m = 32'hBAD0_BAD0;
          wc++;
        end
      end else begin
        bus.rdy = 1'b0;
        bus.data_s2m = 32'hBAD0_BAD0;
        wc = 0;
      end
      en_prev = bus.en;
      done_prev = done;
    end
  end

  // Byte sink + tx monitor: ready raised after tx_stall idle cycles; the
  // presented byte is consumed at the next posedge and checked here.
  initial begin
    int sc = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid && !rst) begin
        if (sc >= tx_stall) begin
          tx_ready = 1'b1;
          sc = 0;
          if (txq.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected actual=%0h required none", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
          end
        end else begin
          tx_ready = 1'b0;
          sc++;
        end
      end else begin
        tx_ready = 1'b0;
        sc = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (rx_ready) begin
        @(negedge clk);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL rx_accept_timeout actual=not accepted required=accepted byte=%0h", b);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input int gap);
    foreach (p[i]) send_byte(p[i], gap);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (busq.size() == 0 && txq.size() == 0) begin
        repeat (4) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s_timeout actual bus=%0d tx=%0d pending required 0", name, busq.size(), txq.size());
    busq.delete();
    txq.delete();
  endtask

  initial begin
    logic [7:0] pkt[$];
    int r0, c0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_en", 32'(bus.en), 32'h0);
    chk("rst_rnw", 32'(bus.rnw), 32'h1);
    chk("rst_addr", bus.address, 32'h0);
    chk("rst_wdata", bus.data_m2s, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'h1);

    // 1: write, slave ready after 3 cycles
    slave_delay = 3; r0 = en_rise;
    exp_bus(1'b0, 32'hC000_0004, 32'hDEAD_BEEF);
    txq.push_back(8'h4B);
    pkt = {8'h57, 8'hC0, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(pkt, 0);
    wait_done("t1");
    chk("t1_en_pulses", 32'(en_rise - r0), 32'd1);

    // 2: read, rdy in first en cycle
    slave_delay = 0; slave_rdata = 32'h1234_5678;
    exp_bus(1'b1, 32'hC000_0008, 32'h0);
    txq.push_back(8'h12); txq.push_back(8'h34); txq.push_back(8'h56); txq.push_back(8'h78);
    pkt = {8'h52, 8'hC0, 8'h00, 8'h00, 8'h08};
    send_pkt(pkt, 0);
    wait_done("t2");

    // 3: bad command then a normal write
    r0 = en_rise;
    txq.push_back(8'h3F);
    send_byte(8'h41, 0);
    wait_done("t3a");
    chk("t3_no_bus", 32'(en_rise - r0), 32'd0);
    exp_bus(1'b0, 32'h0000_0010, 32'hCAFE_F00D);
    txq.push_back(8'h4B);
    pkt = {8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_pkt(pkt, 0);
    wait_done("t3b");

    // 4: rx gaps and tx backpressure
    tx_stall = 5; slave_delay = 2; r0 = en_rise;
    exp_bus(1'b0, 32'h1020_3040, 32'h0102_0304);
    txq.push_back(8'h4B);
    pkt = {8'h57, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(pkt, 3);
    wait_done("t4a");
    slave_rdata = 32'hA5B6_C7D8;
    exp_bus(1'b1, 32'h1020_3040, 32'h0);
    txq.push_back(8'hA5); txq.push_back(8'hB6); txq.push_back(8'hC7); txq.push_back(8'hD8);
    pkt = {8'h52, 8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(pkt, 3);
    wait_done("t4b");
    chk("t4_en_pulses", 32'(en_rise - r0), 32'd2);
    tx_stall = 0;

    // 5: reset mid-packet and mid-transfer
    slave_delay = 1000;
    pkt = {8'h52, 8'hC0, 8'h00, 8'h00};
    send_pkt(pkt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5a_en", 32'(bus.en), 32'h0);
    chk("t5a_tx_valid", 32'(tx_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    pkt = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    send_pkt(pkt, 0);
    chk("t5_en_reached", 32'(bus.en), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5b_en", 32'(bus.en), 32'h0);
    chk("t5b_tx_valid", 32'(tx_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    slave_delay = 1; slave_rdata = 32'hCAFE_BABE;
    exp_bus(1'b1, 32'h0000_0040, 32'h0);
    txq.push_back(8'hCA); txq.push_back(8'hFE); txq.push_back(8'hBA); txq.push_back(8'hBE);
    pkt = {8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
    send_pkt(pkt, 0);
    wait_done("t5c");

    // 6: slave never ready
    slave_delay = 1000; c0 = en_cyc;
    pkt = {8'h52, 8'h00, 8'h00, 8'h00, 8'h50};
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    txq.push_back(8'h54);
    send_pkt(pkt, 0);
    wait_done("t6");
    chk("t6_en_cycles", 32'(en_cyc - c0), 32'd16);
`else
    send_pkt(pkt, 0);
    repeat (40) @(negedge clk);
    chk("t6_en_held", 32'(bus.en), 32'h1);
    chk("t6_no_tx", 32'(tx_valid), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_en_after_rst", 32'(bus.en), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
`endif

    chk("end_busq_empty", 32'(busq.size()), 32'h0);
    chk("end_txq_empty", 32'(txq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
